// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared constants and FSM state type for the block data memory
package data_memory_pkg;

    localparam int MEM_WORD_W      = 32;
    localparam int MEM_BLOCK_W     = 4 * MEM_WORD_W;
    localparam int DEFAULT_ADDR_W  = 6;
    // Access latency shared with the data cache and its testbench.
    localparam int DEFAULT_LATENCY = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - multi-cycle block memory behind the data cache
//
// Ports:
//   CLK           system clock, rising edge
//   RESET         asynchronous active-low reset
//   MEM_READ      block read request
//   MEM_WRITE     block write request (wins over MEM_READ when both are high)
//   MEM_ADDRESS   block address
//   MEM_WRITEDATA block to write, word 0 in bits [31:0]
//   MEM_READDATA  last completed read result, held until the next read
//   MEM_BUSYWAIT  stall to the cache while a request is pending or in progress
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int BLOCK_W = MEM_BLOCK_W,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               MEM_READ,
    input  logic               MEM_WRITE,
    input  logic [ADDR_W-1:0]  MEM_ADDRESS,
    input  logic [BLOCK_W-1:0] MEM_WRITEDATA,
    output logic [BLOCK_W-1:0] MEM_READDATA,
    output logic               MEM_BUSYWAIT
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "data_memory: LATENCY must be in 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    mem_state_t         state;
    logic [3:0]         count;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] data_q;
    logic               wr_q;

    // Storage has no reset; contents are undefined until written.
    logic [BLOCK_W-1:0] mem [2**ADDR_W];

    logic finish;
    assign finish = (state == BUSY) && (count == 4'd0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            count        <= 4'd0;
            addr_q       <= '0;
            data_q       <= '0;
            wr_q         <= 1'b0;
            MEM_READDATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_READ || MEM_WRITE) begin
                        addr_q <= MEM_ADDRESS;
                        data_q <= MEM_WRITEDATA;
                        wr_q   <= MEM_WRITE;
                        count  <= CNT_INIT;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == 4'd0) begin
                        if (!wr_q) begin
                            MEM_READDATA <= mem[addr_q];
                        end
                        state <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                // One non-busy cycle; a still-held request is deliberately ignored.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A reset during BUSY forces IDLE asynchronously, so finish never fires
    // and an aborted write leaves the array untouched.
    always_ff @(posedge CLK) begin
        if (finish && wr_q) begin
            mem[addr_q] <= data_q;
        end
    end

    // Combinational in IDLE so the cache stalls in the same cycle it asks.
    always_comb begin
        MEM_BUSYWAIT = 1'b0;
        case (state)
            IDLE:    MEM_BUSYWAIT = MEM_READ | MEM_WRITE;
            BUSY:    MEM_BUSYWAIT = 1'b1;
            DONE:    MEM_BUSYWAIT = 1'b0;
            default: MEM_BUSYWAIT = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - randomized self-checking bench for data_memory
module tb_data_memory;
    import data_memory_pkg::*;

    localparam int AW  = DEFAULT_ADDR_W;
    localparam int BW  = MEM_BLOCK_W;
    localparam int LAT = DEFAULT_LATENCY;

    logic          clk;
    logic          rst_n;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_writedata;
    logic [BW-1:0] mem_readdata;
    logic          mem_busywait;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: plain block array plus the last read result.
    logic [BW-1:0] model_mem [2**AW];
    logic [BW-1:0] model_rd;

    data_memory #(.ADDR_W(AW), .BLOCK_W(BW), .LATENCY(LAT)) dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .MEM_READ      (mem_read),
        .MEM_WRITE     (mem_write),
        .MEM_ADDRESS   (mem_address),
        .MEM_WRITEDATA (mem_writedata),
        .MEM_READDATA  (mem_readdata),
        .MEM_BUSYWAIT  (mem_busywait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One complete access as the cache would perform it. scramble drives
    // other address/data during BUSY; hold keeps the request into DONE.
    task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                             input logic [BW-1:0] d, input bit hold, input bit scramble,
                             input logic [AW-1:0] s_addr, input logic [BW-1:0] s_data);
        int n;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_address = a; mem_writedata = d;
        #1;
        check_val("bw_request", {127'd0, mem_busywait}, 128'd1);
        n = 0;
        forever begin
            @(negedge clk);
            if (!mem_busywait) break;
            n++;
            if (scramble) begin
                mem_address = s_addr; mem_writedata = s_data;
            end
            if (n > 40) begin
                check_val("busy_timeout", 128'(n), 128'(LAT));
                break;
            end
        end
        check_val("latency", 128'(n), 128'(LAT));
        if (wr) model_mem[a] = d;
        else if (rd) model_rd = model_mem[a];
        check_val("readdata", mem_readdata, model_rd);
        if (hold) begin
            @(negedge clk);
            check_val("bw_hold_idle", {127'd0, mem_busywait}, 128'd1);
            mem_read = 1'b0; mem_write = 1'b0;
            #1;
            check_val("bw_drop", {127'd0, mem_busywait}, 128'd0);
            @(negedge clk);
            check_val("no_replay", {127'd0, mem_busywait}, 128'd0);
            check_val("readdata_after_hold", mem_readdata, model_rd);
        end else begin
            mem_read = 1'b0; mem_write = 1'b0;
        end
    endtask

    initial begin
        logic [BW-1:0] blk_a, blk_b, blk_c, blk_d;
        mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_writedata = '0;
        model_rd = '0;

        // Reset then idle
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("reset_bw", {127'd0, mem_busywait}, 128'd0);
            check_val("reset_rdata", mem_readdata, 128'd0);
        end

        // Fill every block so later reads have defined expectations.
        for (int i = 0; i < 2**AW; i++)
            do_access(1'b0, 1'b1, AW'(i), rand_block(), 1'b0, 1'b0, '0, '0);

        // Write then read back, with the read held into DONE.
        do_access(1'b0, 1'b1, 6'h05, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0, 1'b0, '0, '0);
        do_access(1'b1, 1'b0, 6'h05, '0, 1'b1, 1'b0, '0, '0);
        check_val("dir_read5", mem_readdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);

        // Input changes during BUSY are ignored.
        blk_a = rand_block(); blk_b = ~blk_a;
        do_access(1'b0, 1'b1, 6'h02, blk_a, 1'b0, 1'b1, 6'h03, blk_b);
        do_access(1'b1, 1'b0, 6'h02, '0, 1'b0, 1'b0, '0, '0);
        check_val("dir_block2", mem_readdata, blk_a);
        do_access(1'b1, 1'b0, 6'h03, '0, 1'b0, 1'b0, '0, '0);

        // Simultaneous read+write: write wins, readdata keeps prior value.
        blk_c = rand_block();
        do_access(1'b1, 1'b1, 6'h3F, blk_c, 1'b0, 1'b0, '0, '0);
        check_val("rw_keep_rdata", mem_readdata, model_mem[6'h03]);
        do_access(1'b1, 1'b0, 6'h3F, '0, 1'b0, 1'b0, '0, '0);
        check_val("rw_block63", mem_readdata, blk_c);

        // Reset in the middle of a write aborts it.
        blk_d = rand_block();
        @(negedge clk);
        mem_write = 1'b1; mem_address = 6'h07; mem_writedata = blk_d;
        @(negedge clk);
        mem_write = 1'b0; mem_address = '0; mem_writedata = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_bw", {127'd0, mem_busywait}, 128'd0);
        check_val("abort_rdata", mem_readdata, 128'd0);
        model_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("abort_idle_bw", {127'd0, mem_busywait}, 128'd0);
        do_access(1'b1, 1'b0, 6'h07, '0, 1'b0, 1'b0, '0, '0);

        // Random traffic against the model.
        for (int i = 0; i < 80; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(1, 3));
            do_access(op[0], op[1], AW'($urandom), rand_block(),
                      bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                      AW'($urandom), rand_block());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
